// File: rtl/mips_cpu_alu_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// master = requester/ALU side, slave = arbiter.
interface mips_cpu_alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_sa;
    logic [4:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_sa;

    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_sa;
    logic [31:0] alu_result;
    logic        alu_zero;

    modport slave (
        input  req_valid, req0_op, req0_a, req0_b, req0_sa,
               req1_op, req1_a, req1_b, req1_sa, rsp_ready,
               alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err,
               alu_op, alu_a, alu_b, alu_sa
    );

    modport master (
        output req_valid, req0_op, req0_a, req0_b, req0_sa,
               req1_op, req1_a, req1_b, req1_sa, rsp_ready,
               alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err,
               alu_op, alu_a, alu_b, alu_sa
    );
endinterface

// File: rtl/mips_cpu_alu_arbiter.sv
// Two-requester arbiter for one combinational ALU: accept -> EXEC -> RESP, response 2 cycles after accept,
// held until the owner's rsp_ready. Opcode range check built only with MIPS_ALU_ARB_OPCHK_EN.
module mips_cpu_alu_arbiter #(
    parameter bit          RR_EN   = 1'b1,
    parameter int unsigned LAST_OP = 12
) (
    input  logic                        clk,
    input  logic                        reset_n,
    mips_cpu_alu_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  sa_q, sa_d;
    logic        bad_q, bad_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;

    logic        gnt_vld;
    logic        gnt;
    logic [4:0]  gnt_op;
    logic [31:0] gnt_a;
    logic [31:0] gnt_b;
    logic [4:0]  gnt_sa;
    logic        op_bad;

    // Grant choice; with both valid, round-robin favours whoever did not win last.
    always_comb begin
        gnt_vld = |bus.req_valid;
        gnt     = 1'b0;
        if (bus.req_valid == 2'b11) begin
            gnt = RR_EN ? ~last_grant_q : 1'b0;
        end else begin
            gnt = bus.req_valid[1];
        end
        gnt_op = gnt ? bus.req1_op : bus.req0_op;
        gnt_a  = gnt ? bus.req1_a  : bus.req0_a;
        gnt_b  = gnt ? bus.req1_b  : bus.req0_b;
        gnt_sa = gnt ? bus.req1_sa : bus.req0_sa;
    end

`ifdef MIPS_ALU_ARB_OPCHK_EN
    assign op_bad = (32'(gnt_op) > LAST_OP);
`else
    logic [4:0] unused_last_op;
    assign unused_last_op = 5'(LAST_OP);
    assign op_bad         = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        sa_d          = sa_q;
        bad_d         = bad_q;
        result_d      = result_q;
        zero_d        = zero_q;
        err_d         = err_q;
        bus.req_ready = 2'b00;

        unique case (state_q)
            IDLE: begin
                // Ready is withheld while reset is asserted so nothing is accepted then.
                if (gnt_vld && reset_n) begin
                    bus.req_ready = gnt ? 2'b10 : 2'b01;
                    op_d          = gnt_op;
                    a_d           = gnt_a;
                    b_d           = gnt_b;
                    sa_d          = gnt_sa;
                    bad_d         = op_bad;
                    owner_d       = gnt;
                    last_grant_d  = gnt;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                result_d = bad_q ? 32'd0 : bus.alu_result;
                zero_d   = bad_q ? 1'b1  : bus.alu_zero;
                err_d    = bad_q;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sa_q         <= '0;
            bad_q        <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sa_q         <= sa_d;
            bad_q        <= bad_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    // ALU is fed only from the operand registers, so it stays quiet between ops.
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_sa     = sa_q;

    assign bus.rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_mips_cpu_alu_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter, each with a small ALU model.
module tb_mips_cpu_alu_arbiter;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    mips_cpu_alu_arbiter_if r ();
    mips_cpu_alu_arbiter_if f ();

    mips_cpu_alu_arbiter #(.RR_EN(1'b1), .LAST_OP(12)) dut_rr (
        .clk(clk), .reset_n(reset_n), .bus(r)
    );
    mips_cpu_alu_arbiter #(.RR_EN(1'b0), .LAST_OP(12)) dut_fp (
        .clk(clk), .reset_n(reset_n), .bus(f)
    );

    // 2: add, 3: sub, 8: arithmetic right shift of b by sa; others give a marker.
    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sa);
        case (op)
            5'd2:    alu_f = a + b;
            5'd3:    alu_f = a - b;
            5'd8:    alu_f = 32'($signed(b) >>> sa);
            default: alu_f = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign r.alu_result = alu_f(r.alu_op, r.alu_a, r.alu_b, r.alu_sa);
    assign r.alu_zero   = (r.alu_result == 32'd0);
    assign f.alu_result = alu_f(f.alu_op, f.alu_a, f.alu_b, f.alu_sa);
    assign f.alu_zero   = (f.alu_result == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        r.req_valid = 2'b00; r.rsp_ready = 2'b00;
        r.req0_op = 5'd0; r.req0_a = 32'd0; r.req0_b = 32'd0; r.req0_sa = 5'd0;
        r.req1_op = 5'd0; r.req1_a = 32'd0; r.req1_b = 32'd0; r.req1_sa = 5'd0;
        f.req_valid = 2'b00; f.rsp_ready = 2'b00;
        f.req0_op = 5'd0; f.req0_a = 32'd0; f.req0_b = 32'd0; f.req0_sa = 5'd0;
        f.req1_op = 5'd0; f.req1_a = 32'd0; f.req1_b = 32'd0; f.req1_sa = 5'd0;

        #12;
        chk("rst_req_ready", r.req_ready, 2'b00);
        chk("rst_rsp_valid", r.rsp_valid, 2'b00);
        chk("rst_result", r.rsp_result, 32'd0);
        chk("rst_zero", r.rsp_zero, 1'b0);
        chk("rst_err", r.rsp_err, 1'b0);
        chk("rst_alu_op", r.alu_op, 5'd0);
        chk("rst_alu_a", r.alu_a, 32'd0);
        reset_n = 1'b1;
        step();

        // Single req0 add: 5 + 7
        r.req0_op = 5'd2; r.req0_a = 32'd5; r.req0_b = 32'd7; r.req_valid = 2'b01;
        #1 chk("t2_ready_c0", r.req_ready, 2'b01);
        step();
        r.req_valid = 2'b00;
        chk("t2_exec_ready", r.req_ready, 2'b00);
        chk("t2_exec_rsp", r.rsp_valid, 2'b00);
        chk("t2_alu_a", r.alu_a, 32'd5);
        chk("t2_alu_b", r.alu_b, 32'd7);
        chk("t2_alu_op", r.alu_op, 5'd2);
        step();
        chk("t2_rsp_valid_c2", r.rsp_valid, 2'b01);
        chk("t2_result", r.rsp_result, 32'd12);
        chk("t2_zero", r.rsp_zero, 1'b0);
        r.rsp_ready = 2'b01;
        step();
        r.rsp_ready = 2'b00;
        chk("t2_done", r.rsp_valid, 2'b00);

        // Reset while in EXEC after a req0 grant
        r.req_valid = 2'b01;
        #1 chk("t1_ready", r.req_ready, 2'b01);
        step();
        r.req_valid = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        chk("t1_rsp_valid", r.rsp_valid, 2'b00);
        chk("t1_req_ready", r.req_ready, 2'b00);
        chk("t1_alu_a", r.alu_a, 32'd0);
        chk("t1_alu_op", r.alu_op, 5'd0);
        chk("t1_result", r.rsp_result, 32'd0);
        r.req0_op = 5'd3; r.req0_a = 32'd9; r.req0_b = 32'd9;
        r.req1_op = 5'd3; r.req1_a = 32'd9; r.req1_b = 32'd9;
        r.req_valid = 2'b11;
        #1 chk("t1_ready_in_rst", r.req_ready, 2'b00);
        step();
        reset_n = 1'b1;
        #1 chk("t1_first_grant", r.req_ready, 2'b01);

        // Round-robin with both continuously valid
        r.rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] oh;
            oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("t3_grant%0d", i), r.req_ready, oh);
            step();
            chk($sformatf("t3_exec%0d", i), r.rsp_valid, 2'b00);
            step();
            chk($sformatf("t3_rsp%0d", i), r.rsp_valid, oh);
            chk($sformatf("t3_res%0d", i), r.rsp_result, 32'd0);
            chk($sformatf("t3_zero%0d", i), r.rsp_zero, 1'b1);
            step();
        end
        r.req_valid = 2'b00;
        r.rsp_ready = 2'b00;

        // Fixed priority: req0 always wins
        f.req0_op = 5'd2; f.req0_a = 32'd1;  f.req0_b = 32'd2;
        f.req1_op = 5'd2; f.req1_a = 32'd10; f.req1_b = 32'd20;
        f.req_valid = 2'b11; f.rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_grant%0d", i), f.req_ready, 2'b01);
            step();
            chk($sformatf("t4_exec_rdy%0d", i), f.req_ready, 2'b00);
            step();
            chk($sformatf("t4_rsp%0d", i), f.rsp_valid, 2'b01);
            chk($sformatf("t4_res%0d", i), f.rsp_result, 32'd3);
            chk($sformatf("t4_rsp_rdy%0d", i), f.req_ready, 2'b00);
            step();
        end
        f.req_valid = 2'b00;
        f.rsp_ready = 2'b00;

        // req1 shift with response backpressure; req0 waits behind it
        r.req1_op = 5'd8; r.req1_a = 32'd0; r.req1_b = 32'h8000_0000; r.req1_sa = 5'd4;
        r.req_valid = 2'b10;
        #1 chk("t5_grant1", r.req_ready, 2'b10);
        step();
        r.req0_op = 5'd2; r.req0_a = 32'd5; r.req0_b = 32'd7; r.req0_sa = 5'd0;
        r.req_valid = 2'b01;
        r.rsp_ready = 2'b01;
        #1 chk("t5_exec_ready", r.req_ready, 2'b00);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_hold_vld%0d", i), r.rsp_valid, 2'b10);
            chk($sformatf("t5_hold_res%0d", i), r.rsp_result, 32'hF800_0000);
            chk($sformatf("t5_hold_rdy%0d", i), r.req_ready, 2'b00);
            step();
        end
        r.rsp_ready = 2'b10;
        step();
        chk("t5_release_vld", r.rsp_valid, 2'b00);
        chk("t5_next_grant", r.req_ready, 2'b01);
        step();
        r.req_valid = 2'b00;
        r.rsp_ready = 2'b00;
        step();
        chk("t5_req0_vld", r.rsp_valid, 2'b01);
        chk("t5_req0_res", r.rsp_result, 32'd12);
        r.rsp_ready = 2'b01;
        step();

        // Out-of-range opcode
        r.req0_op = 5'd20; r.req0_a = 32'd1; r.req0_b = 32'd1;
        r.req_valid = 2'b01;
        #1 chk("t6_grant", r.req_ready, 2'b01);
        step();
        r.req_valid = 2'b00;
        chk("t6_alu_op", r.alu_op, 5'd20);
        step();
        chk("t6_vld", r.rsp_valid, 2'b01);
`ifdef MIPS_ALU_ARB_OPCHK_EN
        chk("t6_err", r.rsp_err, 1'b1);
        chk("t6_res", r.rsp_result, 32'd0);
        chk("t6_zero", r.rsp_zero, 1'b1);
`else
        chk("t6_err", r.rsp_err, 1'b0);
        chk("t6_res", r.rsp_result, 32'hDEAD_BEEF);
        chk("t6_zero", r.rsp_zero, 1'b0);
`endif
        step();
        r.req0_op = 5'd2;
        r.req_valid = 2'b01;
        step();
        r.req_valid = 2'b00;
        step();
        chk("t6_legal_res", r.rsp_result, 32'd2);
        chk("t6_legal_err", r.rsp_err, 1'b0);
        step();
        chk("t6_done", r.rsp_valid, 2'b00);
        r.rsp_ready = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
